// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Fetch looks up PCF combinationally and supplies the predicted
//   next PC. Execute compares the resolved outcome against the prediction
//   that was piped down with the instruction, raises a redirect on a
//   mispredict, and updates the table on the clock edge.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   PCF             fetch PC
//   PredTakenF      fetch prediction: taken
//   PredTargetF     predicted next PC (BTB target or PCF+4)
//   ValidE          execute slot holds a real instruction
//   BranchE/JumpE/JalrE  control-type flags of the execute instruction
//   PCE             execute PC
//   PCSrcE          resolved next-PC select, nonzero = taken
//   ActualTargetE   resolved taken target
//   PredTakenE/PredTargetE  prediction carried from F to E
//   MispredictE     redirect required this cycle
//   RedirectPCE     correct next PC on a mispredict
//   BranchCount     saturating count of resolved control instructions
//   MissCount       saturating count of mispredicts
`timescale 1ns/1ps

module branch_predictor #(
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    output logic             PredTakenF,
    output logic [31:0]      PredTargetF,
    input  logic             ValidE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic [31:0]      PCE,
    input  logic [1:0]       PCSrcE,
    input  logic [31:0]      ActualTargetE,
    input  logic             PredTakenE,
    input  logic [31:0]      PredTargetE,
    output logic             MispredictE,
    output logic [31:0]      RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] cnt_q;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [31:0]             target_q [ENTRIES];

    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    logic                hit_f;
    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_W-1:0]    tag_e;
    logic                hit_e;
    logic                ctl_e;
    logic                taken_e;

    // Fetch lookup: reads the registered table only, so a write on the same
    // edge is not visible until the following cycle.
    always_comb begin
        idx_f       = PCF[IDX_BITS+1:2];
        tag_f       = PCF[31:IDX_BITS+2];
        hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        PredTakenF  = hit_f && cnt_q[idx_f][1];
        PredTargetF = PredTakenF ? target_q[idx_f] : (PCF + 32'd4);
    end

    // Execute resolution
    always_comb begin
        idx_e   = PCE[IDX_BITS+1:2];
        tag_e   = PCE[31:IDX_BITS+2];
        hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        ctl_e   = ValidE && (BranchE || JumpE || JalrE);
        taken_e = (PCSrcE != 2'b00);

        MispredictE = 1'b0;
        if (ValidE) begin
            if (ctl_e) begin
                MispredictE = (taken_e != PredTakenE) ||
                              (taken_e && PredTakenE && (ActualTargetE != PredTargetE));
            end else begin
                // A non-control instruction predicted taken hit a stale entry.
                MispredictE = PredTakenE;
            end
        end

        // Non-control instructions always fall through.
        RedirectPCE = (ctl_e && taken_e) ? ActualTargetE : (PCE + 32'd4);
    end

    // Table and counter update
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            cnt_q       <= '0;
            BranchCount <= '0;
            MissCount   <= '0;
        end else begin
            if (ctl_e) begin
                if (hit_e) begin
                    if (taken_e) begin
                        if (cnt_q[idx_e] != 2'b11) cnt_q[idx_e] <= cnt_q[idx_e] + 2'd1;
                        target_q[idx_e] <= ActualTargetE;
                    end else begin
                        if (cnt_q[idx_e] != 2'b00) cnt_q[idx_e] <= cnt_q[idx_e] - 2'd1;
                    end
                end else if (taken_e) begin
                    // Allocate as weakly taken.
                    valid_q[idx_e]  <= 1'b1;
                    tag_q[idx_e]    <= tag_e;
                    target_q[idx_e] <= ActualTargetE;
                    cnt_q[idx_e]    <= 2'b10;
                end
            end else if (ValidE && PredTakenE && hit_e) begin
                valid_q[idx_e] <= 1'b0;
            end

            if (ctl_e && (BranchCount != '1)) BranchCount <= BranchCount + 1'b1;
            if (MispredictE && (MissCount != '1)) MissCount <= MissCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed bench for branch_predictor. Each step drives inputs, pushes the
//   expected observations into a scoreboard queue, and pops/compares them
//   once the combinational outputs have settled (mid-cycle, away from the
//   rising edge). Counter expectations come from a small model kept here.
`timescale 1ns/1ps

module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE;
    logic        BranchE;
    logic        JumpE;
    logic        JalrE;
    logic [31:0] PCE;
    logic [1:0]  PCSrcE;
    logic [31:0] ActualTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [15:0] BranchCount;
    logic [15:0] MissCount;

    branch_predictor #(.IDX_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
        .PCE(PCE), .PCSrcE(PCSrcE), .ActualTargetE(ActualTargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCount(BranchCount), .MissCount(MissCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_bc = 0;
    int   exp_mc = 0;

    function automatic logic [31:0] observe(input string name);
        case (name)
            "PredTakenF":  return {31'b0, PredTakenF};
            "PredTargetF": return PredTargetF;
            "MispredictE": return {31'b0, MispredictE};
            "RedirectPCE": return RedirectPCE;
            "BranchCount": return {16'b0, BranchCount};
            "MissCount":   return {16'b0, MissCount};
            default:       return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    // Let outputs settle, then drain the scoreboard against the DUT.
    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #4;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.name);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic v, input logic br, input logic j, input logic jr,
                           input logic [31:0] pce, input logic [1:0] src,
                           input logic [31:0] act, input logic pt, input logic [31:0] ptgt);
        ValidE = v; BranchE = br; JumpE = j; JalrE = jr;
        PCE = pce; PCSrcE = src; ActualTargetE = act;
        PredTakenE = pt; PredTargetE = ptgt;
    endtask

    task automatic bubble();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0);
    endtask

    // Expected E-stage outcome; also advances the counter model for the edge.
    task automatic expect_e(input logic misp, input logic [31:0] redirect);
        push("MispredictE", {31'b0, misp});
        if (misp) push("RedirectPCE", redirect);
        if (ValidE && (BranchE || JumpE || JalrE) && exp_bc < 32'hFFFF) exp_bc++;
        if (misp && exp_mc < 32'hFFFF) exp_mc++;
    endtask

    task automatic expect_f(input logic taken, input logic [31:0] target);
        push("PredTakenF", {31'b0, taken});
        push("PredTargetF", target);
    endtask

    task automatic expect_counts();
        push("BranchCount", exp_bc[31:0]);
        push("MissCount", exp_mc[31:0]);
    endtask

    initial begin
        rst = 1'b1;
        PCF = 32'h100;
        bubble();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_f(1'b0, 32'h104);
        expect_counts();
        expect_e(1'b0, 32'h0);
        check_all();
        tick();

        // Cold taken branch at 0x100 -> 0x80; fetch of same index sees old entry
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 2'b01, 32'h80, 1'b0, 32'h104);
        expect_e(1'b1, 32'h80);
        expect_f(1'b0, 32'h104);
        check_all();
        tick();
        bubble();
        expect_f(1'b1, 32'h80);
        expect_counts();
        check_all();
        tick();

        // Hysteresis: taken twice (cnt 2->3->3)
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 2'b01, 32'h80, 1'b1, 32'h80);
        expect_e(1'b0, 32'h0);
        check_all();
        tick();
        expect_e(1'b0, 32'h0);
        check_all();
        tick();
        // Not taken once (cnt 3->2): mispredict, still predicts taken
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 2'b00, 32'h80, 1'b1, 32'h80);
        expect_e(1'b1, 32'h104);
        check_all();
        tick();
        bubble();
        expect_f(1'b1, 32'h80);
        check_all();
        tick();
        // Not taken again (cnt 2->1): now predicts not taken
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 2'b00, 32'h80, 1'b1, 32'h80);
        expect_e(1'b1, 32'h104);
        check_all();
        tick();
        bubble();
        expect_f(1'b0, 32'h104);
        expect_counts();
        check_all();
        tick();

        // JALR at 0x204: allocate to 0x200, then hit with target change to 0x240
        PCF = 32'h204;
        drive_e(1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 2'b10, 32'h200, 1'b0, 32'h208);
        expect_e(1'b1, 32'h200);
        check_all();
        tick();
        drive_e(1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 2'b10, 32'h240, 1'b1, 32'h200);
        expect_f(1'b1, 32'h200);
        expect_e(1'b1, 32'h240);
        check_all();
        tick();
        bubble();
        expect_f(1'b1, 32'h240);
        expect_counts();
        check_all();
        tick();

        // Simultaneous read/write at 0x100 (cnt 1->2): old prediction this cycle
        PCF = 32'h100;
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 2'b01, 32'h80, 1'b0, 32'h104);
        expect_f(1'b0, 32'h104);
        expect_e(1'b1, 32'h80);
        check_all();
        tick();
        // Bubble carrying taken-looking inputs must not update anything
        drive_e(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 2'b01, 32'h300, 1'b1, 32'h80);
        expect_f(1'b1, 32'h80);
        expect_e(1'b0, 32'h0);
        check_all();
        tick();
        expect_f(1'b1, 32'h80);
        expect_counts();
        check_all();
        tick();

        // Drive BranchCount to all-ones with not-taken misses at 0x400
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 2'b00, 32'h0, 1'b0, 32'h404);
        repeat (32'hFFFF - exp_bc) @(posedge clk);
        #1;
        exp_bc = 32'hFFFF;
        expect_counts();
        check_all();
        tick();
        // One more resolution: stays saturated (previous check cycle resolved one too)
        expect_e(1'b0, 32'h0);
        expect_counts();
        check_all();
        tick();
        bubble();
        expect_counts();
        expect_f(1'b1, 32'h80);
        check_all();
        tick();

        // Stale entry: non-control instruction at 0x100 predicted taken
        drive_e(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 2'b00, 32'h0, 1'b1, 32'h80);
        expect_e(1'b1, 32'h104);
        check_all();
        tick();
        bubble();
        expect_f(1'b0, 32'h104);
        expect_counts();
        check_all();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
